// File: rtl/addr_reg_ctrl_if.sv
// addr_reg_ctrl_if
// Groups the corner/frame/ack inputs and the bank-write/batch outputs of the
// feature-point address write sequencer.
//   slave  : the sequencer itself (takes detector/matcher inputs, drives bank
//            write port and batch status)
//   master : the surrounding pipeline (detector, frame control, matcher)
// Signals:
//   cornerValid/cornerAddr : corner strobe and its pixel address
//   frameEnd               : one-cycle end-of-frame pulse
//   matchAck               : matcher has consumed the batch
//   refAddr/posAddr/posWe  : bank write port (data, slot, strobe)
//   posReaden/posCount     : batch valid and number of entries in it
//   dropCount              : saturating count of dropped corners
//   busy                   : sequencer is flushing or reporting
interface addr_reg_ctrl_if #(
    parameter int ADDR_W = 15,
    parameter int SLOT_W = 4,
    parameter int DROP_W = 8
) ();
    logic              cornerValid;
    logic [ADDR_W-1:0] cornerAddr;
    logic              frameEnd;
    logic              matchAck;
    logic [ADDR_W-1:0] refAddr;
    logic [SLOT_W-1:0] posAddr;
    logic              posWe;
    logic              posReaden;
    logic [SLOT_W:0]   posCount;
    logic [DROP_W-1:0] dropCount;
    logic              busy;

    modport slave (
        input  cornerValid, cornerAddr, frameEnd, matchAck,
        output refAddr, posAddr, posWe, posReaden, posCount, dropCount, busy
    );

    modport master (
        output cornerValid, cornerAddr, frameEnd, matchAck,
        input  refAddr, posAddr, posWe, posReaden, posCount, dropCount, busy
    );
endinterface

// File: rtl/addr_reg_ctrl.sv
// addr_reg_ctrl
// Write sequencer for the 16-entry feature-point address bank. Each accepted
// corner is written to the next free slot; a full bank or an end of frame with
// at least one entry releases the batch to the matcher, which holds until
// acknowledged. Corners arriving while a batch is pending are dropped and
// counted (saturating).
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : addr_reg_ctrl_if.slave (see interface header for signal list)
module addr_reg_ctrl #(
    parameter int ADDR_W = 15,
    parameter int SLOT_W = 4,
    parameter int DROP_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    addr_reg_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FLUSH   = 2'd1,
        REPORT  = 2'd2
    } state_e;

    localparam logic [SLOT_W:0]   COUNT_FULL = {1'b1, {SLOT_W{1'b0}}};
    localparam logic [SLOT_W:0]   COUNT_ZERO = {(SLOT_W+1){1'b0}};
    localparam logic [SLOT_W:0]   COUNT_ONE  = {{SLOT_W{1'b0}}, 1'b1};
    localparam logic [DROP_W-1:0] DROP_MAX   = {DROP_W{1'b1}};
    localparam logic [DROP_W-1:0] DROP_ONE   = {{(DROP_W-1){1'b0}}, 1'b1};

    state_e            state_q,      state_d;
    logic [ADDR_W-1:0] ref_addr_q,   ref_addr_d;
    logic [SLOT_W-1:0] pos_addr_q,   pos_addr_d;
    logic              pos_we_q,     pos_we_d;
    logic              pos_readen_q, pos_readen_d;
    logic [SLOT_W:0]   pos_count_q,  pos_count_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic              busy_q,       busy_d;

    // Next-state and output computation for the collect/flush/report sequence.
    always_comb begin
        state_d      = state_q;
        ref_addr_d   = ref_addr_q;
        pos_addr_d   = pos_addr_q;
        pos_we_d     = 1'b0;
        pos_readen_d = pos_readen_q;
        pos_count_d  = pos_count_q;
        drop_count_d = drop_count_q;

        case (state_q)
            COLLECT: begin
                if (bus.cornerValid) begin
                    ref_addr_d  = bus.cornerAddr;
                    pos_addr_d  = pos_count_q[SLOT_W-1:0];
                    pos_we_d    = 1'b1;
                    pos_count_d = pos_count_q + COUNT_ONE;
                end else begin
                    pos_count_d = pos_count_q;
                end
                // Decisions use the count after any same-cycle corner, so a
                // corner coinciding with frameEnd joins the batch.
                if (pos_count_d == COUNT_FULL) begin
                    state_d = FLUSH;
                end else if (bus.frameEnd && (pos_count_d != COUNT_ZERO)) begin
                    state_d = FLUSH;
                end else begin
                    state_d = COLLECT;
                end
            end
            FLUSH: begin
                // One settle cycle for the last bank write before release.
                pos_readen_d = 1'b1;
                state_d      = REPORT;
            end
            REPORT: begin
                if (bus.matchAck) begin
                    pos_readen_d = 1'b0;
                    pos_count_d  = COUNT_ZERO;
                    state_d      = COLLECT;
                end else begin
                    state_d = REPORT;
                end
            end
            default: begin
                pos_readen_d = 1'b0;
                pos_count_d  = COUNT_ZERO;
                state_d      = COLLECT;
            end
        endcase

        // Any corner seen outside COLLECT (including the ack cycle) is dropped.
        if (bus.cornerValid && (state_q != COLLECT) && (drop_count_q != DROP_MAX)) begin
            drop_count_d = drop_count_q + DROP_ONE;
        end else begin
            drop_count_d = drop_count_d;
        end

        busy_d = (state_d != COLLECT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            ref_addr_q   <= {ADDR_W{1'b0}};
            pos_addr_q   <= {SLOT_W{1'b0}};
            pos_we_q     <= 1'b0;
            pos_readen_q <= 1'b0;
            pos_count_q  <= COUNT_ZERO;
            drop_count_q <= {DROP_W{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ref_addr_q   <= ref_addr_d;
            pos_addr_q   <= pos_addr_d;
            pos_we_q     <= pos_we_d;
            pos_readen_q <= pos_readen_d;
            pos_count_q  <= pos_count_d;
            drop_count_q <= drop_count_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.refAddr   = ref_addr_q;
    assign bus.posAddr   = pos_addr_q;
    assign bus.posWe     = pos_we_q;
    assign bus.posReaden = pos_readen_q;
    assign bus.posCount  = pos_count_q;
    assign bus.dropCount = drop_count_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_addr_reg_ctrl.sv
// tb_addr_reg_ctrl
// Scoreboard bench: stimulus pushes expected bank writes {slot,addr} and
// expected batch sizes into queues; a negedge monitor pops and compares on
// every posWe pulse and every rising edge of posReaden. Cycle-exact timing
// and status points are checked directly from the stimulus thread.
module tb_addr_reg_ctrl;
    localparam int ADDR_W = 15;
    localparam int SLOT_W = 4;
    localparam int DROP_W = 8;

    logic clk;
    logic rst_n;

    addr_reg_ctrl_if #(.ADDR_W(ADDR_W), .SLOT_W(SLOT_W), .DROP_W(DROP_W)) bus ();

    addr_reg_ctrl #(.ADDR_W(ADDR_W), .SLOT_W(SLOT_W), .DROP_W(DROP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp;
    int n_bad;

    logic [SLOT_W+ADDR_W-1:0] wr_q[$];
    logic [SLOT_W:0]          rep_q[$];
    logic                     prev_readen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each bank write and each batch release against queues.
    always @(negedge clk) begin
        logic [SLOT_W+ADDR_W-1:0] ew;
        logic [SLOT_W:0]          ec;
        if (bus.posWe === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: slot %0d addr 0x%0h, none expected", bus.posAddr, bus.refAddr);
            end else begin
                ew = wr_q.pop_front();
                chk("write_slot", int'(bus.posAddr), int'(ew[SLOT_W+ADDR_W-1:ADDR_W]));
                chk("write_addr", int'(bus.refAddr), int'(ew[ADDR_W-1:0]));
            end
        end
        if (bus.posReaden === 1'b1 && prev_readen !== 1'b1) begin
            if (rep_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_report: posCount %0d, none expected", bus.posCount);
            end else begin
                ec = rep_q.pop_front();
                chk("report_count", int'(bus.posCount), int'(ec));
            end
        end
        prev_readen = bus.posReaden;
    end

    task automatic step(input logic cv, input logic [ADDR_W-1:0] a, input logic fe, input logic ack);
        bus.cornerValid = cv;
        bus.cornerAddr  = a;
        bus.frameEnd    = fe;
        bus.matchAck    = ack;
        @(posedge clk);
        #1;
        bus.cornerValid = 1'b0;
        bus.frameEnd    = 1'b0;
        bus.matchAck    = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Accepted corner: expect it written to the given slot.
    task automatic corner(input logic [ADDR_W-1:0] a, input int slot, input logic fe);
        wr_q.push_back({slot[SLOT_W-1:0], a});
        step(1'b1, a, fe, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_refAddr"},   int'(bus.refAddr),   0);
        chk({tag, "_posAddr"},   int'(bus.posAddr),   0);
        chk({tag, "_posWe"},     int'(bus.posWe),     0);
        chk({tag, "_posReaden"}, int'(bus.posReaden), 0);
        chk({tag, "_posCount"},  int'(bus.posCount),  0);
        chk({tag, "_dropCount"}, int'(bus.dropCount), 0);
        chk({tag, "_busy"},      int'(bus.busy),      0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        prev_readen = 1'b0;
        bus.cornerValid = 1'b0;
        bus.cornerAddr  = '0;
        bus.frameEnd    = 1'b0;
        bus.matchAck    = 1'b0;
        rst_n = 1'b0;
        idle();
        idle();
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Full batch of 16 back-to-back corners.
        for (int i = 0; i < 16; i++) begin
            if (i == 15) rep_q.push_back(5'd16);
            corner(15'h0100 + 15'(i), i, 1'b0);
        end
        chk("full_flush_busy",    int'(bus.busy),      1);
        chk("full_flush_count",   int'(bus.posCount),  16);
        chk("full_flush_readen",  int'(bus.posReaden), 0);
        idle();
        chk("full_report_readen", int'(bus.posReaden), 1);
        chk("full_report_busy",   int'(bus.busy),      1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("full_ack_readen",    int'(bus.posReaden), 0);
        chk("full_ack_count",     int'(bus.posCount),  0);
        chk("full_ack_busy",      int'(bus.busy),      0);

        // Five corners then frameEnd.
        for (int i = 0; i < 5; i++) corner(15'h0200 + 15'(i), i, 1'b0);
        rep_q.push_back(5'd5);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("fe5_flush_readen",  int'(bus.posReaden), 0);
        chk("fe5_flush_busy",    int'(bus.busy),      1);
        idle();
        chk("fe5_report_readen", int'(bus.posReaden), 1);
        idle();
        chk("fe5_hold_readen",   int'(bus.posReaden), 1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("fe5_ack_readen",    int'(bus.posReaden), 0);
        chk("fe5_ack_count",     int'(bus.posCount),  0);

        // frameEnd with empty bank is ignored.
        step(1'b0, '0, 1'b1, 1'b0);
        chk("fe0_busy",   int'(bus.busy),      0);
        idle();
        chk("fe0_readen", int'(bus.posReaden), 0);
        chk("fe0_busy2",  int'(bus.busy),      0);

        // frameEnd together with a corner: corner joins the batch.
        rep_q.push_back(5'd1);
        corner(15'h7FFF, 0, 1'b1);
        idle();
        chk("fec_readen", int'(bus.posReaden), 1);
        chk("fec_count",  int'(bus.posCount),  1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Full batch, ack withheld while 300 corners are dropped.
        for (int i = 0; i < 16; i++) begin
            if (i == 15) rep_q.push_back(5'd16);
            corner(15'h0300 + 15'(i), i, 1'b0);
        end
        idle();
        for (int i = 0; i < 300; i++) step(1'b1, 15'h1000 + 15'(i), 1'b0, 1'b0);
        chk("drop_sat",         int'(bus.dropCount), 255);
        chk("drop_readen_held", int'(bus.posReaden), 1);
        step(1'b1, 15'h2222, 1'b0, 1'b1);
        chk("drop_ack_readen",  int'(bus.posReaden), 0);
        chk("drop_ack_sat",     int'(bus.dropCount), 255);
        corner(15'h0ABC, 0, 1'b0);
        chk("after_ack_count",  int'(bus.posCount),  1);
        rep_q.push_back(5'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        idle();
        step(1'b0, '0, 1'b0, 1'b1);

        // Reset while reporting a batch of 9.
        for (int i = 0; i < 9; i++) corner(15'h0400 + 15'(i), i, 1'b0);
        rep_q.push_back(5'd9);
        step(1'b0, '0, 1'b1, 1'b0);
        idle();
        chk("pre_rst_count", int'(bus.posCount), 9);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        chk_all_zero("midrst");
        rep_q.push_back(5'd1);
        corner(15'h0555, 0, 1'b1);
        idle();
        chk("rst_batch_readen", int'(bus.posReaden), 1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Stray matchAck in COLLECT is ignored.
        corner(15'h0600, 0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("stray_count1",  int'(bus.posCount),  1);
        chk("stray_readen1", int'(bus.posReaden), 0);
        corner(15'h0601, 1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("stray_count2",  int'(bus.posCount),  2);
        chk("stray_busy",    int'(bus.busy),      0);
        rep_q.push_back(5'd2);
        step(1'b0, '0, 1'b1, 1'b0);
        idle();
        step(1'b0, '0, 1'b0, 1'b1);
        idle();

        chk("writes_left",  wr_q.size(),  0);
        chk("reports_left", rep_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
